// File: rtl/cirno_sequencer_if.sv
// Bundle of the sequencer's handshake and bus signals.
//   master : the sequencer side (drives fetch/decode/exec strobes, pc, status)
//   slave  : the environment side (imem, decoder, register file, dmem, start)
// Signals:
//   start                          : leave IDLE and begin fetching at pc
//   imem_req / imem_ack            : instruction fetch handshake, imem_rdata valid with ack
//   inst / decoder_en              : latched instruction and one-cycle decode strobe
//   inst_type, branch, branchi,
//   immediate, done                : registered decoder outputs, valid in EXEC
//   reg_x                          : register-file read data, branch target
//   alu_en / reg_wr_en             : ALU and register-file write strobes
//   dmem_req / dmem_we / dmem_ack  : data memory handshake, we=1 for store
//   pc / halted / retired          : program counter, halt flag, retired count
interface cirno_sequencer_if #(
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             imem_req;
  logic             imem_ack;
  logic [8:0]       imem_rdata;
  logic [8:0]       inst;
  logic             decoder_en;
  logic [2:0]       inst_type;
  logic             branch;
  logic             branchi;
  logic [5:0]       immediate;
  logic             done;
  logic [7:0]       reg_x;
  logic             alu_en;
  logic             reg_wr_en;
  logic             dmem_req;
  logic             dmem_we;
  logic             dmem_ack;
  logic [PC_W-1:0]  pc;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, imem_ack, imem_rdata, inst_type, branch, branchi, immediate, done, reg_x,
           dmem_ack,
    output imem_req, inst, decoder_en, alu_en, reg_wr_en, dmem_req, dmem_we, pc, halted, retired
  );

  modport slave (
    output start, imem_ack, imem_rdata, inst_type, branch, branchi, immediate, done, reg_x,
           dmem_ack,
    input  imem_req, inst, decoder_en, alu_en, reg_wr_en, dmem_req, dmem_we, pc, halted, retired
  );
endinterface

// File: rtl/cirno_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the Cirno core.
// Owns the PC, fetches 9-bit instructions over a req/ack port, pulses decoder_en, then steps
// the ALU, register file and data memory from the decoder's registered outputs.
// Ports:
//   clk     : clock, all state updates on posedge
//   rst     : asynchronous active-high reset
//   bus_io  : cirno_sequencer_if.master (fetch, decode, exec, memory and status signals)
// Parameters:
//   PC_W     : PC width, PC arithmetic wraps modulo 2**PC_W
//   RESET_PC : PC loaded on reset
//   CNT_W    : width of the saturating retired-instruction counter
module cirno_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  cirno_sequencer_if.master bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [2:0] TypeAlu   = 3'd1;
  localparam logic [2:0] TypeBri   = 3'd2;
  localparam logic [2:0] TypeBr    = 3'd3;
  localparam logic [2:0] TypeMove  = 3'd4;
  localparam logic [2:0] TypeStore = 3'd5;
  localparam logic [2:0] TypeLoad  = 3'd6;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [8:0]       inst_q, inst_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  // Access direction captured in EXEC so dmem_we stays stable for the whole MEM phase.
  logic             is_store_q, is_store_d;

  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_rel;
  logic [PC_W-1:0]  reg_tgt;
  logic             retire;
  logic             exec_live;

  assign pc_inc    = pc_q + PC_W'(1);
  // Sized cast of a signed operand sign-extends the 6-bit offset; the add wraps naturally.
  assign pc_rel    = pc_q + PC_W'($signed(bus_io.immediate));
  assign reg_tgt   = PC_W'(bus_io.reg_x);
  // EXEC strobes are suppressed when the decoder flags a halt.
  assign exec_live = (state_q == StExec) && !bus_io.done;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    is_store_d = is_store_q;
    retire     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) state_d = StFetch;
      end

      StFetch: begin
        if (bus_io.imem_ack) begin
          inst_d  = bus_io.imem_rdata;
          state_d = StDecode;
        end
      end

      StDecode: begin
        state_d = StExec;
      end

      StExec: begin
        if (bus_io.done) begin
          state_d = StHalt;
        end else begin
          case (bus_io.inst_type)
            TypeBri, TypeBr: begin
              // Immediate branch wins over register branch; neither means not-taken/nop.
              if (bus_io.branchi) begin
                pc_d = pc_rel;
              end else if (bus_io.branch) begin
                pc_d = reg_tgt;
              end else begin
                pc_d = pc_inc;
              end
              state_d = StFetch;
              retire  = 1'b1;
            end
            TypeStore, TypeLoad: begin
              is_store_d = (bus_io.inst_type == TypeStore);
              state_d    = StMem;
            end
            // ALU, move and unknown codes all simply advance.
            default: begin
              pc_d    = pc_inc;
              state_d = StFetch;
              retire  = 1'b1;
            end
          endcase
        end
      end

      StMem: begin
        if (bus_io.dmem_ack) begin
          if (is_store_q) begin
            pc_d    = pc_inc;
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end

      StWb: begin
        pc_d    = pc_inc;
        state_d = StFetch;
        retire  = 1'b1;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != '1)) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      retired_q  <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      retired_q  <= retired_d;
      is_store_q <= is_store_d;
    end
  end

  // Outputs decode the registered state, so an async reset drops every request immediately.
  // alu_en/reg_wr_en in EXEC also qualify on the decoder's registered type and done flag.
  assign bus_io.imem_req   = (state_q == StFetch);
  assign bus_io.decoder_en = (state_q == StDecode);
  assign bus_io.alu_en     = exec_live && (bus_io.inst_type == TypeAlu);
  assign bus_io.reg_wr_en  = (exec_live && (bus_io.inst_type == TypeMove)) || (state_q == StWb);
  assign bus_io.dmem_req   = (state_q == StMem);
  assign bus_io.dmem_we    = (state_q == StMem) && is_store_q;
  assign bus_io.halted     = (state_q == StHalt);
  assign bus_io.pc         = pc_q;
  assign bus_io.inst       = inst_q;
  assign bus_io.retired    = retired_q;

endmodule
